// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings used by the ALU, the decoder and
// the multiplier sequencer, plus the sequencer's state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier that borrows the shared ALU, one ADD per granted
// cycle. It produces the low WIDTH bits of the unsigned product.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] Multiplicand,
    input  logic [WIDTH-1:0] Multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Product,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [3:0]       ALU_Operation,
    output logic [WIDTH-1:0] Data1,
    output logic [WIDTH-1:0] Data2,
    input  logic [WIDTH-1:0] ALU_result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST_COUNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO_W     = {WIDTH{1'b0}};

    mul_state_e       state_r;
    logic [WIDTH-1:0] m_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] acc_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] product_r;
    logic [WIDTH-1:0] data2_r;
    logic [3:0]       alu_op_r;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic             alu_req_r;

    logic [WIDTH-1:0] m_next_s;
    logic [WIDTH-1:0] q_next_s;
    logic             last_step_s;

    // Shifted operands and the termination test for the current RUN step.
    always_comb begin
        m_next_s    = m_r << 1;
        q_next_s    = q_r >> 1;
        last_step_s = 1'b0;
        if ((q_next_s == ZERO_W) || (count_r == LAST_COUNT)) begin
            last_step_s = 1'b1;
        end else begin
            last_step_s = 1'b0;
        end
    end

    // Sequencer FSM. acc_r doubles as the Data1 output register, and every
    // ALU-facing output is registered, so alu_req never depends on alu_gnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            m_r       <= ZERO_W;
            q_r       <= ZERO_W;
            acc_r     <= ZERO_W;
            count_r   <= {CW{1'b0}};
            product_r <= ZERO_W;
            data2_r   <= ZERO_W;
            alu_op_r  <= ALU_AND;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            alu_req_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        ready_r <= 1'b0;
                        acc_r   <= ZERO_W;
                        if (Multiplier != ZERO_W) begin
                            m_r       <= Multiplicand;
                            q_r       <= Multiplier;
                            count_r   <= {CW{1'b0}};
                            data2_r   <= Multiplier[0] ? Multiplicand : ZERO_W;
                            alu_op_r  <= ALU_ADD;
                            busy_r    <= 1'b1;
                            alu_req_r <= 1'b1;
                            state_r   <= ST_RUN;
                        end else begin
                            // Zero multiplier: skip RUN, the ALU is never requested.
                            product_r <= ZERO_W;
                            done_r    <= 1'b1;
                            state_r   <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    // Without a grant everything holds and the ALU inputs stay valid.
                    if (alu_gnt) begin
                        m_r     <= m_next_s;
                        q_r     <= q_next_s;
                        count_r <= count_r + CW'(1);
                        if (last_step_s) begin
                            product_r <= ALU_result;
                            acc_r     <= ZERO_W;
                            data2_r   <= ZERO_W;
                            alu_op_r  <= ALU_AND;
                            busy_r    <= 1'b0;
                            alu_req_r <= 1'b0;
                            done_r    <= 1'b1;
                            state_r   <= ST_DONE;
                        end else begin
                            acc_r   <= ALU_result;
                            data2_r <= q_next_s[0] ? m_next_s : ZERO_W;
                        end
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    acc_r     <= ZERO_W;
                    data2_r   <= ZERO_W;
                    alu_op_r  <= ALU_AND;
                    ready_r   <= 1'b1;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    alu_req_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready         = ready_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign Product       = product_r;
    assign alu_req       = alu_req_r;
    assign ALU_Operation = alu_op_r;
    assign Data1         = acc_r;
    assign Data2         = data2_r;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural shared ALU, a step model
// of the shift-and-add datapath and a product scoreboard.
module tb_alu_mul_seq;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             ready;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product;
    logic             alu_req;
    logic             alu_gnt;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [WIDTH-1:0] alu_result;

    int checks   = 0;
    int failures = 0;
    logic [WIDTH-1:0] exp_q[$];

    always #5 clk = ~clk;

    alu_mul_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
        .Multiplicand(multiplicand), .Multiplier(multiplier),
        .busy(busy), .done(done), .Product(product),
        .alu_req(alu_req), .alu_gnt(alu_gnt), .ALU_Operation(alu_op),
        .Data1(data1), .Data2(data2), .ALU_result(alu_result)
    );

    // Shared ALU
    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_AND: alu_result = data1 & data2;
            ALU_OR:  alu_result = data1 | data2;
            ALU_ADD: alu_result = data1 + data2;
            ALU_SUB: alu_result = data1 - data2;
            default: alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},   ready,   32'd1);
        chk({tag, "_busy"},    busy,    32'd0);
        chk({tag, "_done"},    done,    32'd0);
        chk({tag, "_alu_req"}, alu_req, 32'd0);
        chk({tag, "_product"}, product, 32'd0);
        chk({tag, "_data1"},   data1,   32'd0);
        chk({tag, "_data2"},   data2,   32'd0);
        chk({tag, "_alu_op"},  alu_op,  32'(ALU_AND));
    endtask

    // Called at a negedge in an IDLE cycle; returns at the negedge of cycle k+2.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit alt_gnt, input bit hold, input bit inject,
                          input int exp_done);
        logic [WIDTH-1:0] m_m, q_m, acc_m, exp_p;
        bit run_m, seen, last;
        int cnt_m, cyc;
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        alu_gnt      = 1'b1;
        exp_q.push_back(a * b);
        run_m = (b != '0);
        m_m = a; q_m = b; acc_m = '0; cnt_m = 0; cyc = 0; seen = 1'b0;
        exp_p = '0;
        @(posedge clk);
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (!hold) start = 1'b0;
            if (inject && cyc == 2) begin
                start = 1'b1; multiplicand = 32'd99; multiplier = 32'd77;
            end else if (inject && cyc == 3) begin
                start = 1'b0;
            end
            chk("alu_req", alu_req, 32'(run_m));
            chk("busy", busy, 32'(run_m));
            if (run_m) begin
                chk("run_done", done, 32'd0);
                chk("run_ready", ready, 32'd0);
                chk("run_op", alu_op, 32'(ALU_ADD));
                chk("data1", data1, acc_m);
                chk("data2", data2, q_m[0] ? m_m : 32'd0);
                alu_gnt = alt_gnt ? (cyc % 2 == 0) : 1'b1;
                if (alu_gnt) begin
                    acc_m = acc_m + (q_m[0] ? m_m : 32'd0);
                    cnt_m++;
                    last  = ((q_m >> 1) == '0) || (cnt_m == WIDTH);
                    m_m   = m_m << 1;
                    q_m   = q_m >> 1;
                    if (last) run_m = 1'b0;
                end
            end else begin
                chk("idle_op", alu_op, 32'(ALU_AND));
                chk("idle_data1", data1, 32'd0);
                chk("idle_data2", data2, 32'd0);
                if (done) begin
                    seen = 1'b1;
                    chk("done_cycle", cyc, exp_done);
                    chk("done_ready", ready, 32'd0);
                    exp_p = exp_q.pop_front();
                    chk("product", product, exp_p);
                end
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        @(negedge clk);
        chk("after_ready", ready, 32'd1);
        chk("after_done", done, 32'd0);
        chk("after_product", product, exp_p);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; alu_gnt = 1'b0;
        multiplicand = '0; multiplier = '0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("post_reset");

        run_op(32'd7, 32'd6, 1'b0, 1'b0, 1'b0, 4);
        run_op(32'h0000_1234, 32'd0, 1'b0, 1'b0, 1'b0, 1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 33);
        chk("sq_product", product, 32'h0000_0001);
        run_op(32'h1234_5678, 32'd9, 1'b1, 1'b0, 1'b0, 9);
        chk("alt_product", product, 32'hA3D7_0A38);
        run_op(32'd7, 32'd6, 1'b0, 1'b0, 1'b1, 4);

        // Abort a long operation with an asynchronous reset pulse.
        alu_gnt = 1'b1; multiplicand = 32'd7; multiplier = 32'h8000_0000; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_abort_busy", busy, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 4);

        run_op(32'd5, 32'd3, 1'b0, 1'b1, 1'b0, 3);
        run_op(32'd2, 32'd2, 1'b0, 1'b0, 1'b0, 3);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
